// File: rtl/fxp_pkg.sv
// Shared definitions for the pipelined fixed-point multiplier: rounding/overflow mode
// encodings and helpers that build the signed range limits for a given result width.
package fxp_pkg;

    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;
    localparam logic OVF_WRAP    = 1'b0;
    localparam logic OVF_SAT     = 1'b1;

    // Helpers return a wide vector; callers keep only the low w bits.
    localparam int FXP_MAX_W = 128;

    function automatic logic [FXP_MAX_W-1:0] fxp_signed_max(input int w);
        logic [FXP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FXP_MAX_W; i++) begin
            if (i < w - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [FXP_MAX_W-1:0] fxp_signed_min(input int w);
        logic [FXP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < FXP_MAX_W; i++) begin
            if (i == w - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Final-stage arithmetic: takes the full-width signed product, optionally rounds half up,
// drops the fractional bits and either wraps or clamps the result, flagging any overflow.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 12
) (
    input  logic signed [2*DATA_WIDTH-1:0] product,
    input  logic                           round_en,
    input  logic                           sat_en,
    output logic        [DATA_WIDTH-1:0]   result,
    output logic                           ovf
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [FXP_MAX_W-1:0]  MAX_FULL = fxp_signed_max(DATA_WIDTH);
    localparam logic [FXP_MAX_W-1:0]  MIN_FULL = fxp_signed_min(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MAX_VAL  = MAX_FULL[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] MIN_VAL  = MIN_FULL[DATA_WIDTH-1:0];

    localparam logic signed [PW-1:0] HALF_LSB = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

    logic signed [PW-1:0]         rounded;
    logic signed [PW-1:0]         shifted;
    logic        [PW-DATA_WIDTH:0] upper;

    // The result fits only if every bit from the result sign bit upward is identical.
    always_comb begin
        rounded = (round_en == RND_HALF_UP) ? product + HALF_LSB : product;
        shifted = rounded >>> FRAC_BITS;
        upper   = shifted[PW-1:DATA_WIDTH-1];
        ovf     = !((&upper) || !(|upper));
        result  = shifted[DATA_WIDTH-1:0];
        if (ovf && (sat_en == OVF_SAT)) begin
            result = shifted[PW-1] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/fxp_mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control, per-transaction
// round/saturate modes and a saturating count of overflowing results.
module fxp_mult_pipe
    import fxp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 12,
    parameter int STAGES     = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  round_en,
    input  logic                  sat_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  ovf,
    output logic [CNT_WIDTH-1:0]  ovf_count,
    input  logic                  cnt_clr
);

    localparam int PW = 2 * DATA_WIDTH;

    logic                  advance;
    logic                  accept;
    logic signed [PW-1:0]  a_ext;
    logic signed [PW-1:0]  b_ext;
    logic signed [PW-1:0]  product_in;

    logic                  fin_valid;
    logic signed [PW-1:0]  fin_product;
    logic                  fin_round;
    logic                  fin_sat;

    logic [DATA_WIDTH-1:0] rs_result;
    logic                  rs_ovf;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // One stall signal freezes every stage, so nothing is lost or duplicated under back-pressure.
    assign advance    = !(out_valid_q && !out_ready);
    assign in_ready   = advance;
    assign accept     = in_valid && advance;
    assign a_ext      = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign b_ext      = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign product_in = a_ext * b_ext;

    if (STAGES == 1) begin : g_direct
        assign fin_valid   = accept;
        assign fin_product = product_in;
        assign fin_round   = round_en;
        assign fin_sat     = sat_en;
    end else begin : g_pipe
        localparam int NP = STAGES - 1;

        logic [NP-1:0]         vld_q, vld_d;
        logic [NP-1:0]         rnd_q, rnd_d;
        logic [NP-1:0]         sat_q, sat_d;
        logic [NP-1:0][PW-1:0] prod_q, prod_d;

        // Product stage followed by plain register stages; modes travel with their operands.
        always_comb begin
            vld_d  = vld_q;
            rnd_d  = rnd_q;
            sat_d  = sat_q;
            prod_d = prod_q;
            if (advance) begin
                vld_d[0] = accept;
                if (accept) begin
                    prod_d[0] = product_in;
                    rnd_d[0]  = round_en;
                    sat_d[0]  = sat_en;
                end
                for (int i = 1; i < NP; i++) begin
                    vld_d[i] = vld_q[i-1];
                    if (vld_q[i-1]) begin
                        prod_d[i] = prod_q[i-1];
                        rnd_d[i]  = rnd_q[i-1];
                        sat_d[i]  = sat_q[i-1];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q  <= '0;
                rnd_q  <= '0;
                sat_q  <= '0;
                prod_q <= '0;
            end else begin
                vld_q  <= vld_d;
                rnd_q  <= rnd_d;
                sat_q  <= sat_d;
                prod_q <= prod_d;
            end
        end

        assign fin_valid   = vld_q[NP-1];
        assign fin_product = prod_q[NP-1];
        assign fin_round   = rnd_q[NP-1];
        assign fin_sat     = sat_q[NP-1];
    end

    fxp_round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_round_sat (
        .product  (fin_product),
        .round_en (fin_round),
        .sat_en   (fin_sat),
        .result   (rs_result),
        .ovf      (rs_ovf)
    );

    // Output register keeps its last data when a bubble arrives; clear beats a same-cycle count.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ovf_d       = ovf_q;
        if (advance) begin
            out_valid_d = fin_valid;
            if (fin_valid) begin
                out_d = rs_result;
                ovf_d = rs_ovf;
            end
        end
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && out_ready && ovf_q && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Directed bench for fxp_mult_pipe: three instances (STAGES 1, 2, 4) driven side by side,
// hand-computed Q20.12 vectors, a back-pressured stream, counter and reset scenarios.
module tb_fxp_mult_pipe;

    localparam int W  = 32;
    localparam int ND = 3;
    localparam int NS = 20;

    logic clk = 1'b0;
    logic rst;

    logic [ND-1:0] in_valid_v, round_v, sat_v, rdy_v, clr_v;
    logic [W-1:0]  a_v [ND];
    logic [W-1:0]  b_v [ND];
    logic [ND-1:0] in_ready_w, out_valid_w, ovf_w;
    logic [W-1:0]  out_w [ND];
    logic [15:0]   cnt_w [ND];
    logic [15:0]   cnt_s1, cnt_s2;
    logic [3:0]    cnt4;

    int lat [ND] = '{1, 2, 4};
    int checks = 0;
    int errors = 0;

    logic [W-1:0] sa [NS];
    logic [W-1:0] sb [NS];
    logic         sr [NS];
    logic         ss [NS];
    logic [W-1:0] em_out [NS];
    logic         em_ovf [NS];
    int           idx [ND];
    int           ocnt [ND];

    always #5 clk = ~clk;

    fxp_mult_pipe #(.DATA_WIDTH(32), .FRAC_BITS(12), .STAGES(1), .CNT_WIDTH(16)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
        .a(a_v[0]), .b(b_v[0]), .round_en(round_v[0]), .sat_en(sat_v[0]),
        .out_valid(out_valid_w[0]), .out_ready(rdy_v[0]), .out(out_w[0]), .ovf(ovf_w[0]),
        .ovf_count(cnt_s1), .cnt_clr(clr_v[0]));

    fxp_mult_pipe #(.DATA_WIDTH(32), .FRAC_BITS(12), .STAGES(2), .CNT_WIDTH(16)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
        .a(a_v[1]), .b(b_v[1]), .round_en(round_v[1]), .sat_en(sat_v[1]),
        .out_valid(out_valid_w[1]), .out_ready(rdy_v[1]), .out(out_w[1]), .ovf(ovf_w[1]),
        .ovf_count(cnt_s2), .cnt_clr(clr_v[1]));

    // Narrow counter on this instance so saturation is reachable in a few cycles.
    fxp_mult_pipe #(.DATA_WIDTH(32), .FRAC_BITS(12), .STAGES(4), .CNT_WIDTH(4)) dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
        .a(a_v[2]), .b(b_v[2]), .round_en(round_v[2]), .sat_en(sat_v[2]),
        .out_valid(out_valid_w[2]), .out_ready(rdy_v[2]), .out(out_w[2]), .ovf(ovf_w[2]),
        .ovf_count(cnt4), .cnt_clr(clr_v[2]));

    assign cnt_w[0] = cnt_s1;
    assign cnt_w[1] = cnt_s2;
    assign cnt_w[2] = {12'h000, cnt4};

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_all(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                             input logic r, input logic s);
        for (int k = 0; k < ND; k++) begin
            in_valid_v[k] = v;
            a_v[k]        = aa;
            b_v[k]        = bb;
            round_v[k]    = r;
            sat_v[k]      = s;
        end
    endtask

    function automatic void model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  input logic r, input logic s,
                                  output logic [W-1:0] o, output logic ov);
        longint p;
        longint q;
        p = longint'(signed'(aa)) * longint'(signed'(bb));
        if (r) p = p + 2048;
        q  = p >>> 12;
        ov = (q > 64'sd2147483647) || (q < -64'sd2147483648);
        if (ov && s) o = (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else         o = q[31:0];
    endfunction

    // One transaction into every instance, then exact-latency check of out_valid/out/ovf.
    task automatic apply_stimulus(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  input logic r, input logic s,
                                  input logic [W-1:0] exp_out, input logic exp_ovf);
        @(negedge clk);
        drive_all(1'b1, aa, bb, r, s);
        #1;
        for (int k = 0; k < ND; k++)
            check_output($sformatf("%s in_ready d%0d", name, k), in_ready_w[k], 1'b1);
        @(negedge clk);
        drive_all(1'b0, aa, bb, r, s);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            for (int k = 0; k < ND; k++) begin
                check_output($sformatf("%s valid c%0d d%0d", name, c, k), out_valid_w[k], c == lat[k]);
                if (c == lat[k]) begin
                    check_output($sformatf("%s out d%0d", name, k), out_w[k], exp_out);
                    check_output($sformatf("%s ovf d%0d", name, k), ovf_w[k], exp_ovf);
                end
            end
        end
    endtask

    initial begin
        logic [15:0] t;
        logic        busy;
        int          cyc;

        rst   = 1'b0;
        rdy_v = '1;
        clr_v = '0;
        drive_all(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            check_output($sformatf("rst out_valid d%0d", k), out_valid_w[k], 1'b0);
            check_output($sformatf("rst in_ready d%0d", k), in_ready_w[k], 1'b1);
            check_output($sformatf("rst out d%0d", k), out_w[k], 32'h0);
            check_output($sformatf("rst ovf d%0d", k), ovf_w[k], 1'b0);
            check_output($sformatf("rst cnt d%0d", k), cnt_w[k], 16'h0);
        end
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] directed vectors");
        apply_stimulus("one_x_one",   32'h0000_1000, 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1000, 1'b0);
        apply_stimulus("half_trunc",  32'h0000_0001, 32'h0000_0800, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        apply_stimulus("half_round",  32'h0000_0001, 32'h0000_0800, 1'b1, 1'b0, 32'h0000_0001, 1'b0);
        apply_stimulus("neg_trunc",   32'hFFFF_FFFF, 32'h0000_0800, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        apply_stimulus("neg_round",   32'hFFFF_FFFF, 32'h0000_0800, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
        apply_stimulus("x15_trunc",   32'h0000_0003, 32'h0000_0800, 1'b0, 1'b0, 32'h0000_0001, 1'b0);
        apply_stimulus("x15_round",   32'h0000_0003, 32'h0000_0800, 1'b1, 1'b0, 32'h0000_0002, 1'b0);
        apply_stimulus("three_m_two", 32'h0000_3000, 32'hFFFF_E000, 1'b0, 1'b0, 32'hFFFF_A000, 1'b0);
        apply_stimulus("three_m_sat", 32'h0000_3000, 32'hFFFF_E000, 1'b1, 1'b1, 32'hFFFF_A000, 1'b0);
        apply_stimulus("minmin_sat",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        apply_stimulus("minmin_wrap", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        apply_stimulus("minmax_sat",  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
        for (int k = 0; k < ND; k++)
            check_output($sformatf("cnt after three d%0d", k), cnt_w[k], 16'd3);

        $display("[TB] back-pressured stream");
        for (int i = 0; i < NS; i++) begin
            sa[i] = $urandom;
            t     = 16'($urandom);
            sb[i] = (i % 3 == 0) ? $urandom : {{16{t[15]}}, t};
            sr[i] = 1'($urandom_range(0, 1));
            ss[i] = 1'($urandom_range(0, 1));
            model(sa[i], sb[i], sr[i], ss[i], em_out[i], em_ovf[i]);
        end
        for (int k = 0; k < ND; k++) begin
            idx[k]  = 0;
            ocnt[k] = 0;
        end
        busy = 1'b1;
        cyc  = 0;
        while (busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < ND; k++) begin
                in_valid_v[k] = idx[k] < NS;
                if (idx[k] < NS) begin
                    a_v[k]     = sa[idx[k]];
                    b_v[k]     = sb[idx[k]];
                    round_v[k] = sr[idx[k]];
                    sat_v[k]   = ss[idx[k]];
                end
                rdy_v[k] = 1'($urandom_range(0, 1));
            end
            #1;
            busy = 1'b0;
            for (int k = 0; k < ND; k++) begin
                check_output($sformatf("stream in_ready d%0d", k), in_ready_w[k],
                             !(out_valid_w[k] && !rdy_v[k]));
                if (out_valid_w[k] && rdy_v[k]) begin
                    if (ocnt[k] < NS) begin
                        check_output($sformatf("stream out %0d d%0d", ocnt[k], k), out_w[k], em_out[ocnt[k]]);
                        check_output($sformatf("stream ovf %0d d%0d", ocnt[k], k), ovf_w[k], em_ovf[ocnt[k]]);
                    end
                    ocnt[k]++;
                end
                if (in_valid_v[k] && in_ready_w[k]) idx[k]++;
                if (ocnt[k] < NS || idx[k] < NS) busy = 1'b1;
            end
        end
        @(negedge clk);
        drive_all(1'b0, '0, '0, 1'b0, 1'b0);
        rdy_v = '1;
        for (int k = 0; k < ND; k++)
            check_output($sformatf("stream count d%0d", k), ocnt[k], NS);
        repeat (5) @(negedge clk);
        #1;
        for (int k = 0; k < ND; k++)
            check_output($sformatf("stream drained d%0d", k), out_valid_w[k], 1'b0);

        $display("[TB] counter saturation and clear");
        @(negedge clk);
        clr_v = '1;
        @(negedge clk);
        clr_v = '0;
        #1;
        for (int k = 0; k < ND; k++)
            check_output($sformatf("cnt cleared d%0d", k), cnt_w[k], 16'd0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive_all(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        end
        @(negedge clk);
        drive_all(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        for (int k = 0; k < ND; k++)
            check_output($sformatf("cnt fifteen d%0d", k), cnt_w[k], 16'd15);
        apply_stimulus("one_more_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        check_output("cnt sat d0", cnt_w[0], 16'd16);
        check_output("cnt sat d1", cnt_w[1], 16'd16);
        check_output("cnt sat d2", cnt_w[2], 16'h000F);

        rdy_v = '0;
        @(negedge clk);
        drive_all(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        @(negedge clk);
        drive_all(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            check_output($sformatf("held valid d%0d", k), out_valid_w[k], 1'b1);
            check_output($sformatf("held in_ready d%0d", k), in_ready_w[k], 1'b0);
        end
        @(negedge clk);
        rdy_v = '1;
        clr_v = '1;
        @(negedge clk);
        clr_v = '0;
        #1;
        for (int k = 0; k < ND; k++) begin
            check_output($sformatf("clr beats inc d%0d", k), cnt_w[k], 16'd0);
            check_output($sformatf("clr consumed d%0d", k), out_valid_w[k], 1'b0);
        end

        $display("[TB] reset with work in flight");
        apply_stimulus("pre_reset_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        for (int k = 0; k < ND; k++)
            check_output($sformatf("cnt pre reset d%0d", k), cnt_w[k], 16'd1);
        @(negedge clk);
        drive_all(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clk);
        drive_all(1'b1, 32'h0000_2000, 32'h0000_2000, 1'b0, 1'b0);
        @(negedge clk);
        drive_all(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            check_output($sformatf("mid rst valid d%0d", k), out_valid_w[k], 1'b0);
            check_output($sformatf("mid rst cnt d%0d", k), cnt_w[k], 16'd0);
            check_output($sformatf("mid rst in_ready d%0d", k), in_ready_w[k], 1'b1);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < ND; k++)
                check_output($sformatf("post rst idle c%0d d%0d", c, k), out_valid_w[k], 1'b0);
        end
        apply_stimulus("post_reset", 32'h0000_2000, 32'h0000_2000, 1'b0, 1'b0, 32'h0000_4000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
